bch_rx_deserializer: RTL
========================

# bch_rx_deserializer

Serial front end for the BCH(15,7,t=2) receive path. It collects a 15-bit received codeword from a 1-bit stream and computes the GF(16) syndromes S1 and S3 incrementally as the bits arrive. Each completed word, with its syndromes, is queued in a small FIFO and offered to the downstream combinational decoder over a valid/ready handshake. The decoder then only needs error locator evaluation, Chien search and correction.

## Interface
- FIFO_DEPTH, default 2: output queue entries; power of two, ≥2.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ser_bit  in  1  received bit, most-significant coefficient (r14) first.
- ser_valid  in  1  ser_bit is valid this cycle.
- ser_sof  in  1  start of frame; qualified by ser_valid; marks the r14 bit.
- ovf_clr  in  1  clears sticky overflow.
- word_valid  out  1  FIFO head is valid.
- word_ready  in  1  downstream accepts the head.
- word_data  out  15  codeword; bit i = coefficient of x^i.
- word_s1  out  4  S1 = r(α), polynomial basis.
- word_s3  out  4  S3 = r(α³).
- word_err  out  1  (S1≠0) or (S3≠0).
- overflow  out  1  sticky: a completed word was dropped.
- frame_abort  out  1  one-cycle pulse: a partial frame was discarded.

## Operation
- GF(16) uses primitive polynomial x⁴+x+1: α⁴=3, α¹⁴=9, α¹²=15.
- mul_alpha(v) = {v[2:0],0} ^ (v[3] ? 4'b0011 : 0).
- mul_alpha3 = mul_alpha applied three times; it is a pure XOR network.
- FSM states:
  - IDLE: accepted bits (ser_valid=1) without ser_sof are ignored.
  - COLLECT: bit counter cnt runs 0..14.
- Accepted bit with ser_sof:
  - Enter COLLECT and set cnt=1.
  - Load the shift register with that bit.
  - Load s1_acc and s3_acc with {3'b0, ser_bit}.
  - If this happens in COLLECT with cnt≠0, the partial frame is discarded and frame_abort pulses.
- Accepted bit in COLLECT without ser_sof:
  - sh = {sh[13:0], bit}.
  - s1_acc = mul_alpha(s1_acc) ^ bit.
  - s3_acc = mul_alpha3(s3_acc) ^ bit.
  - cnt increments.
- On acceptance of the 15th bit (cnt==14):
  - Push the completed word and its final syndromes (the next-state values) into the FIFO.
  - Return to IDLE.
- ser_valid=0: all collection state holds; gaps of any length are legal.
- FIFO push when full with no pop in the same cycle: the word is dropped, overflow is set, and FIFO contents are unchanged.
- FIFO push and pop in the same cycle: both succeed, including when the FIFO is full.
- Pop occurs when word_valid && word_ready.
- When word_valid=0, word_data, word_s1 and word_s3 are don't-care but must not be X after reset (zero-initialized storage).
- word_err is derived combinationally from the stored head syndromes.
- overflow clears on ovf_clr=1. If ovf_clr and a new drop occur in the same cycle, overflow remains set.

## Timing
- Reset values:
  - State IDLE, cnt=0, FIFO empty, storage zeroed.
  - word_valid=0, word_data=0, word_s1=0, word_s3=0, word_err=0.
  - overflow=0, frame_abort=0.
- Latency: the 15th bit is sampled at edge N, and word_valid=1 from just after edge N. The latency is one cycle, with no combinational path from ser_* to word_*.
- Throughput: one bit per cycle sustained. A new sof is accepted the cycle after the 15th bit.
- Handshake:
  - word_valid and the head fields stay stable until popped.
  - word_valid never depends combinationally on word_ready.
- frame_abort is registered and high for exactly one cycle after the offending sof edge.
- Reset mid-frame or with the FIFO non-empty: everything returns to the reset values immediately (asynchronously). Nothing is output afterwards until a new sof.

## Structure
- Shared BCH package holds:
  - GF16_PRIM=4'b0011 (reduction constant).
  - BCH_N=15, BCH_K=7.
  - The mul_alpha/mul_alpha3 functions, also used by the decoder's syndrome logic.
- One sub-module, bch_word_fifo: a parameterized synchronous FIFO of {word, s1, s3} with full/empty flags and simultaneous push/pop.
- The top level holds the FSM, counter, shift register and syndrome accumulators.

## Test plan
- Bits of 15'h7FFF (all-ones codeword) back-to-back, sof on the first bit → one cycle later word_valid=1, word_data=7FFF, s1=0, s3=0, word_err=0.
- 15'h4000 (r14 only) → s1=9, s3=15, err=1. 15'h0001 → s1=1, s3=1, err=1.
- Frame sent with random ser_valid gaps → output identical to the gap-free run; stray bits without sof in IDLE produce no word.
- sof reasserted after 6 bits, then a full 15-bit frame → frame_abort one pulse, exactly one word (the second frame) emitted.
- word_ready=0, three frames with FIFO_DEPTH=2 → first two queued in order, third dropped, overflow=1; ovf_clr → 0; pop on the push cycle when full → no drop.
- rst_n pulsed low mid-frame and with the FIFO full → word_valid=0, overflow=0 immediately; the next full frame decodes correctly.

Source files
------------

// File: rtl/bch_rx_deserializer_pkg.sv
// Shared BCH(15,7,t=2) definitions: GF(16) arithmetic over x^4+x+1,
// code dimensions and the record type carried from deserializer to decoder.
package bch_rx_deserializer_pkg;

  localparam logic [3:0] GF16_PRIM = 4'b0011;
  localparam int         BCH_N     = 15;
  localparam int         BCH_K     = 7;

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } rx_state_t;

  typedef struct packed {
    logic [BCH_N-1:0] data;
    logic [3:0]       s1;
    logic [3:0]       s3;
  } bch_word_t;

  // Multiply by alpha in polynomial basis: shift, then fold x^4 back as x+1.
  function automatic logic [3:0] mul_alpha(input logic [3:0] v);
    return {v[2:0], 1'b0} ^ (v[3] ? GF16_PRIM : 4'b0000);
  endfunction

  function automatic logic [3:0] mul_alpha3(input logic [3:0] v);
    return mul_alpha(mul_alpha(mul_alpha(v)));
  endfunction

endpackage

// File: rtl/bch_word_fifo.sv
// Synchronous FIFO of completed codewords with their syndromes; a push and a
// pop in the same cycle both succeed, even when the FIFO is full.
module bch_word_fifo
  import bch_rx_deserializer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  bch_word_t push_word,
  input  logic      pop,
  output bch_word_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  bch_word_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is reset on purpose -- the head is visible on the ports
  // while empty and must read as zero rather than X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_en) begin
        mem[wr_ptr[AW-1:0]] <= push_word;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/bch_rx_deserializer.sv
// Serial receive front end for BCH(15,7): assembles a 15-bit codeword MSB first,
// accumulates S1/S3 by Horner's rule per bit, and queues results for the decoder.
module bch_rx_deserializer
  import bch_rx_deserializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_bit,
  input  logic             ser_valid,
  input  logic             ser_sof,
  input  logic             ovf_clr,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [BCH_N-1:0] word_data,
  output logic [3:0]       word_s1,
  output logic [3:0]       word_s3,
  output logic             word_err,
  output logic             overflow,
  output logic             frame_abort
);

  localparam logic [3:0] LAST_CNT = 4'(BCH_N - 1);

  rx_state_t        state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BCH_N-1:0] sh_q, sh_d;
  logic [3:0]       s1_q, s1_d;
  logic [3:0]       s3_q, s3_d;
  logic             abort_d;
  logic             push;
  bch_word_t        push_word;
  bch_word_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             drop;

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    s1_d    = s1_q;
    s3_d    = s3_q;
    abort_d = 1'b0;
    push    = 1'b0;
    if (ser_valid) begin
      if (ser_sof) begin
        // A sof always restarts collection; any partial frame is thrown away.
        abort_d = (state_q == ST_COLLECT) && (cnt_q != 4'd0);
        state_d = ST_COLLECT;
        cnt_d   = 4'd1;
        sh_d    = {{(BCH_N-1){1'b0}}, ser_bit};
        s1_d    = {3'b000, ser_bit};
        s3_d    = {3'b000, ser_bit};
      end else if (state_q == ST_COLLECT) begin
        sh_d  = {sh_q[BCH_N-2:0], ser_bit};
        s1_d  = mul_alpha(s1_q) ^ {3'b000, ser_bit};
        s3_d  = mul_alpha3(s3_q) ^ {3'b000, ser_bit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          push    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
    end
    push_word.data = sh_d;
    push_word.s1   = s1_d;
    push_word.s3   = s3_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      sh_q        <= '0;
      s1_q        <= 4'd0;
      s3_q        <= 4'd0;
      frame_abort <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      s1_q        <= s1_d;
      s3_q        <= s3_d;
      frame_abort <= abort_d;
    end
  end

  assign pop  = word_valid && word_ready;
  assign drop = push && fifo_full && !pop;

  // A drop in the same cycle as a clear wins, so no loss goes unreported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  bch_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign word_data  = head.data;
  assign word_s1    = head.s1;
  assign word_s3    = head.s3;
  assign word_err   = (head.s1 != 4'd0) || (head.s3 != 4'd0);

endmodule
